fir_tdm_mc: RTL and testbench

Multi-channel, time-multiplexed reconfigurable FIR filter and the successor of the single-channel fir_top. One shared MAC serves CHANNELS independent delay lines. Inputs and outputs carry a channel tag, and both sides use valid/ready handshakes. Coefficients come from COE_LOCAL_NUM parameter banks plus one runtime-reloadable bank. Bank select and reload commit are applied only between samples, never in the middle of a computation.

---
 rtl/fir_tdm_mc.sv | 224 ++++++++++++++++++++++
 tb/tb_fir_tdm_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_mc.sv
`default_nettype none
// ============================================================================
// Module      : fir_tdm_mc
// Description : Multi-channel time-multiplexed FIR filter with one shared MAC,
//               parameter coefficient banks and one runtime-reloadable bank.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tdm_mc #(
    parameter int CHANNELS      = 4,
    parameter int CH_WIDTH      = 2,
    parameter int DATA_IN_WIDTH = 16,
    parameter int COE_WIDTH     = 16,
    parameter int COE_TAPS      = 22,
    parameter int ACC_WIDTH     = 37,
    parameter int OUT_SHIFT     = 0,
    parameter int COE_LOCAL_NUM = 3,
    parameter int COE_SEL_WIDTH = 2,
    parameter logic [COE_LOCAL_NUM*COE_TAPS*COE_WIDTH-1:0] COE_FILE =
        {COE_LOCAL_NUM{{{(COE_WIDTH-1){1'b0}}, 1'b1, {((COE_TAPS-1)*COE_WIDTH){1'b0}}}}}
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 data_vld_i,
    output logic                                 data_ready_o,
    input  logic [CH_WIDTH-1:0]                  data_ch_i,
    input  logic signed [DATA_IN_WIDTH-1:0]      data_i,
    output logic                                 data_vld_o,
    input  logic                                 data_ready_i,
    output logic [CH_WIDTH-1:0]                  data_ch_o,
    output logic signed [ACC_WIDTH-OUT_SHIFT-1:0] data_o,
    input  logic                                 coe_sel_vld_i,
    input  logic [COE_SEL_WIDTH-1:0]             coe_sel_index_i,
    output logic                                 coe_sel_err_o,
    input  logic                                 coe_reload_vld_i,
    input  logic signed [COE_WIDTH-1:0]          coe_reload_data_i,
    output logic                                 coe_reload_done_o,
    output logic                                 data_err_o
);

    localparam int c_k_w    = (COE_TAPS > 1) ? $clog2(COE_TAPS) : 1;
    localparam int c_prod_w = DATA_IN_WIDTH + COE_WIDTH;
    localparam int c_out_w  = ACC_WIDTH - OUT_SHIFT;
    localparam int c_slots  = 2**COE_SEL_WIDTH;
    localparam int c_lanes  = 2**CH_WIDTH;
    localparam logic [CH_WIDTH:0]      c_ch_limit = (CH_WIDTH+1)'(CHANNELS);
    localparam logic [COE_SEL_WIDTH-1:0] c_sel_max = COE_SEL_WIDTH'(COE_LOCAL_NUM);
    localparam logic [c_k_w-1:0]       c_k_last   = c_k_w'(COE_TAPS-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                          r_state;
    logic signed [DATA_IN_WIDTH-1:0] r_dline  [c_lanes][COE_TAPS];
    logic signed [COE_WIDTH-1:0]     r_shadow [COE_TAPS];
    logic signed [COE_WIDTH-1:0]     r_rbank  [COE_TAPS];
    logic [c_k_w-1:0]                r_k;
    logic [c_k_w-1:0]                r_cnt;
    logic [CH_WIDTH-1:0]             r_ch;
    logic signed [ACC_WIDTH-1:0]     r_acc;
    logic [COE_SEL_WIDTH-1:0]        r_act;
    logic [COE_SEL_WIDTH-1:0]        r_sel_idx;
    logic                            r_sel_pend;
    logic                            r_commit;
    logic                            r_rdy;
    logic                            r_vld_o;
    logic [CH_WIDTH-1:0]             r_ch_o;
    logic signed [c_out_w-1:0]       r_data_o;
    logic                            r_sel_err;
    logic                            r_done;
    logic                            r_data_err;

    logic signed [COE_WIDTH-1:0]     w_coef_tbl [c_slots][COE_TAPS];
    logic signed [COE_WIDTH-1:0]     w_coef;
    logic signed [DATA_IN_WIDTH-1:0] w_x;
    logic signed [c_prod_w-1:0]      w_prod;
    logic signed [ACC_WIDTH-1:0]     w_acc_nxt;
    logic signed [ACC_WIDTH-1:0]     w_acc_shr;
    logic                            w_ch_ok;
    logic                            w_take;
    logic                            w_start;
    logic                            w_release;
    logic                            w_commit_set;
    logic                            w_commit_nxt;
    logic                            w_idle_nxt;

    // Slot 0 is the reload bank, slots 1..COE_LOCAL_NUM the parameter banks
    // (bank 1 in the MSBs of COE_FILE, tap 0 in the MS word of each bank).
    for (genvar s = 0; s < c_slots; s++) begin : g_slot
        for (genvar k = 0; k < COE_TAPS; k++) begin : g_tap
            if (s == 0) begin : g_reload
                assign w_coef_tbl[s][k] = r_rbank[k];
            end else if (s <= COE_LOCAL_NUM) begin : g_param
                assign w_coef_tbl[s][k] =
                    COE_FILE[((COE_LOCAL_NUM-s)*COE_TAPS + (COE_TAPS-1-k))*COE_WIDTH +: COE_WIDTH];
            end else begin : g_unused
                assign w_coef_tbl[s][k] = '0;
            end
        end
    end

    assign w_coef    = w_coef_tbl[r_act][r_k];
    assign w_x       = r_dline[r_ch][r_k];
    assign w_prod    = w_x * w_coef;
    assign w_acc_nxt = r_acc + {{(ACC_WIDTH-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
    assign w_acc_shr = r_acc >>> OUT_SHIFT;

    assign w_ch_ok      = ({1'b0, data_ch_i} < c_ch_limit);
    assign w_take       = (r_state == S_IDLE) && r_rdy && data_vld_i;
    assign w_start      = w_take && w_ch_ok;
    assign w_release    = (r_state == S_OUT) && r_vld_o && data_ready_i;
    assign w_commit_set = coe_reload_vld_i && (r_cnt == c_k_last);
    assign w_commit_nxt = w_commit_set || (r_commit && (r_state != S_IDLE));
    assign w_idle_nxt   = ((r_state == S_IDLE) && !w_start) || w_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            for (int c = 0; c < c_lanes; c++) begin
                for (int i = 0; i < COE_TAPS; i++) begin
                    r_dline[c][i] <= '0;
                end
            end
            for (int i = 0; i < COE_TAPS; i++) begin
                r_shadow[i] <= '0;
                r_rbank[i]  <= '0;
            end
            r_k        <= '0;
            r_cnt      <= '0;
            r_ch       <= '0;
            r_acc      <= '0;
            r_act      <= COE_SEL_WIDTH'(1);
            r_sel_idx  <= '0;
            r_sel_pend <= 1'b0;
            r_commit   <= 1'b0;
            r_rdy      <= 1'b0;
            r_vld_o    <= 1'b0;
            r_ch_o     <= '0;
            r_data_o   <= '0;
            r_sel_err  <= 1'b0;
            r_done     <= 1'b0;
            r_data_err <= 1'b0;
        end else begin
            r_sel_err  <= 1'b0;
            r_done     <= 1'b0;
            r_data_err <= 1'b0;
            // Ready is registered, so it anticipates the next state and commit flag.
            r_rdy      <= w_idle_nxt && !w_commit_nxt;
            r_commit   <= w_commit_nxt;

            if (coe_reload_vld_i) begin
                r_shadow[r_cnt] <= coe_reload_data_i;
                r_cnt           <= (r_cnt == c_k_last) ? '0 : r_cnt + 1'b1;
            end
            if ((r_state == S_IDLE) && r_commit) begin
                r_rbank <= r_shadow;
                r_done  <= 1'b1;
            end

            if ((r_state == S_IDLE) && r_sel_pend) begin
                r_act      <= r_sel_idx;
                r_sel_pend <= 1'b0;
            end
            if (coe_sel_vld_i) begin
                if (coe_sel_index_i > c_sel_max) begin
                    r_sel_err <= 1'b1;
                end else begin
                    r_sel_pend <= 1'b1;
                    r_sel_idx  <= coe_sel_index_i;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        if (w_ch_ok) begin
                            for (int i = COE_TAPS-1; i > 0; i--) begin
                                r_dline[data_ch_i][i] <= r_dline[data_ch_i][i-1];
                            end
                            r_dline[data_ch_i][0] <= data_i;
                            r_ch    <= data_ch_i;
                            r_acc   <= '0;
                            r_k     <= '0;
                            r_state <= S_MAC;
                        end else begin
                            r_data_err <= 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    if (r_k == c_k_last) begin
                        r_state <= S_OUT;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_OUT: begin
                    if (!r_vld_o) begin
                        r_vld_o  <= 1'b1;
                        r_data_o <= w_acc_shr[c_out_w-1:0];
                        r_ch_o   <= r_ch;
                    end else if (data_ready_i) begin
                        r_vld_o <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_ready_o      = r_rdy;
    assign data_vld_o        = r_vld_o;
    assign data_ch_o         = r_ch_o;
    assign data_o            = r_data_o;
    assign coe_sel_err_o     = r_sel_err;
    assign coe_reload_done_o = r_done;
    assign data_err_o        = r_data_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_tdm_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_tdm_mc
// Description : Directed self-checking bench for fir_tdm_mc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_tdm_mc;

    localparam int NB = 3;
    localparam int NT = 22;
    localparam int CW = 16;

    // Bank 1: unit impulse, bank 2: {-5,0,4,2, k-12...}, bank 3: all ones.
    function automatic int coef(input int b, input int k);
        if (b == 1) return (k == 0) ? 1 : 0;
        if (b == 2) begin
            case (k)
                0:       return -5;
                1:       return 0;
                2:       return 4;
                3:       return 2;
                default: return k - 12;
            endcase
        end
        if (b == 3) return 1;
        return 0;
    endfunction

    function automatic logic [NB*NT*CW-1:0] mk_file();
        logic [NB*NT*CW-1:0] f;
        f = '0;
        for (int b = 1; b <= NB; b++)
            for (int k = 0; k < NT; k++)
                f[((NB-b)*NT + (NT-1-k))*CW +: CW] = 16'(coef(b, k));
        return f;
    endfunction

    function automatic int rl_word(input int k);
        return 1000*k - 9000;
    endfunction

    localparam logic [NB*NT*CW-1:0] C_FILE = mk_file();

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               data_vld_i = 1'b0;
    logic               data_ready_o;
    logic [2:0]         data_ch_i = '0;
    logic signed [15:0] data_i = '0;
    logic               data_vld_o;
    logic               data_ready_i = 1'b1;
    logic [2:0]         data_ch_o;
    logic signed [36:0] data_o;
    logic               coe_sel_vld_i = 1'b0;
    logic [2:0]         coe_sel_index_i = '0;
    logic               coe_sel_err_o;
    logic               coe_reload_vld_i = 1'b0;
    logic signed [15:0] coe_reload_data_i = '0;
    logic               coe_reload_done_o;
    logic               data_err_o;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    fir_tdm_mc #(
        .CHANNELS(4), .CH_WIDTH(3), .DATA_IN_WIDTH(16), .COE_WIDTH(16),
        .COE_TAPS(NT), .ACC_WIDTH(37), .OUT_SHIFT(0), .COE_LOCAL_NUM(NB),
        .COE_SEL_WIDTH(3), .COE_FILE(C_FILE)
    ) u_dut (
        .clk(clk), .rst(rst),
        .data_vld_i(data_vld_i), .data_ready_o(data_ready_o),
        .data_ch_i(data_ch_i), .data_i(data_i),
        .data_vld_o(data_vld_o), .data_ready_i(data_ready_i),
        .data_ch_o(data_ch_o), .data_o(data_o),
        .coe_sel_vld_i(coe_sel_vld_i), .coe_sel_index_i(coe_sel_index_i),
        .coe_sel_err_o(coe_sel_err_o),
        .coe_reload_vld_i(coe_reload_vld_i), .coe_reload_data_i(coe_reload_data_i),
        .coe_reload_done_o(coe_reload_done_o), .data_err_o(data_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_vld_i = 1'b0; coe_sel_vld_i = 1'b0; coe_reload_vld_i = 1'b0;
        data_ready_i = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic send(input int ch, input int val, output int acc_cyc);
        int n;
        n = 0;
        data_ch_i = 3'(ch); data_i = 16'(val); data_vld_i = 1'b1;
        while (!data_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!data_ready_o) check("send_timeout", 0, 1);
        tick();
        acc_cyc = cyc;
        data_vld_i = 1'b0;
    endtask

    task automatic recv(output int ch, output longint val, output int seen_cyc);
        int n;
        n = 0;
        while (!data_vld_o && n < 100) begin
            tick();
            n++;
        end
        if (!data_vld_o) check("recv_timeout", 0, 1);
        ch = int'(data_ch_o);
        val = longint'(data_o);
        seen_cyc = cyc;
        tick();
    endtask

    task automatic xfer(input string tag, input int ch, input int val,
                        input longint exp, input bit chk_en);
        int a, c, s;
        longint d;
        send(ch, val, a);
        recv(c, d, s);
        if (chk_en) begin
            check({tag, "_data"}, d, exp);
            check({tag, "_ch"}, c, ch);
            check({tag, "_lat"}, s - a, 23);
        end
    endtask

    task automatic sel(input int idx);
        coe_sel_vld_i = 1'b1; coe_sel_index_i = 3'(idx);
        tick();
        coe_sel_vld_i = 1'b0;
    endtask

    task automatic reload_word(input int val);
        coe_reload_vld_i = 1'b1; coe_reload_data_i = 16'(val);
        tick();
        coe_reload_vld_i = 1'b0;
    endtask

    initial begin
        int a, c, s, nv;
        longint d;

        // Reset state
        #1;
        tick();
        check("rst_vld", data_vld_o, 0);
        check("rst_rdy", data_ready_o, 0);
        check("rst_data", data_o, 0);
        check("rst_pulses", {coe_sel_err_o, coe_reload_done_o, data_err_o}, 0);
        do_reset();

        // Passthrough with the default active bank 1
        xfer("pass100", 0, 100, 100, 1'b1);
        xfer("pass_m7", 0, -7, -7, 1'b1);

        // Channel isolation with bank 2
        do_reset();
        sel(2);
        xfer("iso_t0", 2, 1, -5, 1'b1);
        for (int j = 1; j < NT; j++) begin
            for (int ch = 0; ch < 4; ch++) begin
                xfer($sformatf("iso_j%0d_c%0d", j, ch), ch, 0,
                     (ch == 2) ? longint'(coef(2, j)) : 0, 1'b1);
            end
        end

        // Select while a MAC is running
        do_reset();
        send(1, 10, a);
        repeat (3) tick();
        sel(2);
        recv(c, d, s);
        check("selmac_cur", d, 10);
        check("selmac_lat", s - a, 23);
        xfer("selmac_next", 1, 3, -15, 1'b1);

        // Valid index 3, invalid index 4, invalid channel
        sel(3);
        check("sel3_err", coe_sel_err_o, 0);
        sel(4);
        check("sel4_err", coe_sel_err_o, 1);
        tick();
        check("sel4_err_pulse", coe_sel_err_o, 0);
        xfer("b3_a", 3, 5, 5, 1'b1);
        xfer("b3_b", 3, 7, 12, 1'b1);
        xfer("b3_c", 3, 1, 13, 1'b1);
        send(4, 55, a);
        check("badch_err", data_err_o, 1);
        tick();
        check("badch_err_pulse", data_err_o, 0);
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            if (data_vld_o) nv++;
            tick();
        end
        check("badch_no_out", nv, 0);
        check("badch_rdy", data_ready_o, 1);

        // Partial reload has no effect
        for (int k = 0; k < NT - 1; k++) reload_word(rl_word(k));
        check("rl21_done", coe_reload_done_o, 0);
        sel(0);
        xfer("rl21_out", 0, 1, 0, 1'b1);
        reload_word(rl_word(NT - 1));
        check("commit_rdy", data_ready_o, 0);
        check("commit_done0", coe_reload_done_o, 0);
        tick();
        check("commit_done1", coe_reload_done_o, 1);
        check("commit_rdy1", data_ready_o, 1);
        tick();
        check("commit_done2", coe_reload_done_o, 0);
        xfer("rl_t0", 2, 1, rl_word(0), 1'b1);
        for (int k = 1; k < NT; k++)
            xfer($sformatf("rl_t%0d", k), 2, 0, rl_word(k), 1'b1);

        // Extreme values: full-scale negative data and coefficients
        for (int k = 0; k < NT; k++) reload_word(-32768);
        tick();
        for (int k = 0; k < NT - 1; k++) xfer("edge_fill", 1, -32768, 0, 1'b0);
        xfer("edge_full", 1, -32768, 64'sd23622320128, 1'b1);

        // Backpressure in OUT
        sel(1);
        data_ready_i = 1'b0;
        send(0, 42, a);
        nv = 0;
        while (!data_vld_o && nv < 100) begin
            tick();
            nv++;
        end
        check("bp_lat", cyc - a, 23);
        data_ch_i = 3'd3; data_i = -16'sd9; data_vld_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_vld", data_vld_o, 1);
            check("bp_data", data_o, 42);
            check("bp_ch", data_ch_o, 0);
            check("bp_rdy", data_ready_o, 0);
            tick();
        end
        data_ready_i = 1'b1;
        tick();
        check("bp_vld_drop", data_vld_o, 0);
        xfer("bp_held", 3, -9, -9, 1'b1);

        // Reset in the middle of a MAC
        send(0, 77, a);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check("mrst_vld", data_vld_o, 0);
        check("mrst_rdy", data_ready_o, 0);
        check("mrst_data", data_o, 0);
        check("mrst_ch", data_ch_o, 0);
        check("mrst_pulses", {coe_sel_err_o, coe_reload_done_o, data_err_o}, 0);
        do_reset();
        xfer("mrst_imp", 0, 1, 1, 1'b1);
        sel(3);
        xfer("mrst_clean", 0, 0, 1, 1'b1);
        sel(0);
        xfer("mrst_rbank", 0, 5, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
